// File: rtl/pool_max_stream.sv
// pool_max_stream: streaming sign-magnitude max-pool over WIN-sample windows with valid/ready handshakes
module pool_max_stream #(
  parameter int Q    = 16,
  parameter int N    = 32,
  parameter int WIN  = 4,
  parameter int RELU = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);
  localparam int CW = WIN > 1 ? $clog2(WIN) : 1;
  if (WIN < 1 || Q >= N) begin : g_bad
    $error("pool_max_stream: WIN must be >= 1 and Q < N");
  end
  logic [N-1:0]  acc, cand, res;
  logic [CW-1:0] cnt;
  logic          acc_en, close;
  // strict win only, so a tie keeps the incumbent; differing signs make +0 beat -0
  function automatic logic beats(input logic [N-1:0] a, input logic [N-1:0] b);
    return a[N-1] != b[N-1] ? !a[N-1] :
           a[N-1] ? a[N-2:0] < b[N-2:0] : a[N-2:0] > b[N-2:0];
  endfunction
  always_comb begin
    in_ready = !out_valid || out_ready;
    acc_en   = in_valid && in_ready;
    cand     = cnt == '0 || beats(in_data, acc) ? in_data : acc;
    close    = acc_en && (cnt == CW'(WIN - 1) || in_last);
    res      = RELU != 0 && cand[N-1] ? '0 : cand;
    busy     = cnt != '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (acc_en && !close) begin
        acc <= cand;
        cnt <= cnt + 1'b1;
      end
      if (close) begin
        out_data  <= res;
        out_valid <= 1'b1;
        out_last  <= in_last;
        cnt       <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pool_max_stream.sv
// tb_pool_max_stream: directed and random scoreboard bench for pool_max_stream (RELU=0 and RELU=1 in lockstep)
module tb_pool_max_stream;
  localparam int WIN = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, busy;
  logic [31:0] out_data, r_data;
  logic r_in_ready, r_valid, r_last, r_busy;
  int nerr = 0, nchk = 0, cyc = 0, n_out = 0, ready_low = 0, mc = 0;
  logic [32:0] sb[$];
  int out_cyc[$];
  logic [31:0] macc, last_d, last_dr, hd;
  logic last_l, hl, hold_p = 1'b0, rnd_on = 1'b0;

  pool_max_stream #(.Q(16), .N(32), .WIN(WIN), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy));
  pool_max_stream #(.Q(16), .N(32), .WIN(WIN), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(r_in_ready), .out_data(r_data), .out_valid(r_valid), .out_last(r_last),
    .out_ready(out_ready), .busy(r_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // signed ordering key: negatives below positives, -0 just below +0
  function automatic longint key(input logic [31:0] v);
    return v[31] ? -2 * longint'(v[30:0]) : 2 * longint'(v[30:0]) + 1;
  endfunction
  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'h0 : v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mc = 0;
      sb.delete();
      hold_p = 1'b0;
    end else begin
      if (hold_p) chk("hold", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, hl, hd});
      hold_p = out_valid && !out_ready;
      hl = out_last;
      hd = out_data;
      chk("ready", {63'd0, in_ready}, {63'd0, !out_valid || out_ready});
      chk("relu_sync", {60'd0, r_in_ready, r_busy, r_valid, r_last}, {60'd0, in_ready, busy, out_valid, out_last});
      if (!in_ready) ready_low++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious", {63'd0, out_valid}, 64'd0);
        else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("data", {31'd0, out_last, out_data}, {31'd0, e});
          chk("relu_data", {32'd0, r_data}, {32'd0, relu(e[31:0])});
        end
        n_out++;
        last_d = out_data;
        last_dr = r_data;
        last_l = out_last;
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        if (mc == 0 || key(in_data) > key(macc)) macc = in_data;
        if (mc == WIN - 1 || in_last) begin
          sb.push_back({in_last, macc});
          mc = 0;
        end else mc++;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic window(input logic [31:0] a, b, c, d);
    send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, 1'b0);
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset", {29'd0, out_valid, busy, out_last, out_data}, 64'd0);
    chk("reset_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // basic window with latency
    ready_low = 0;
    send(32'h00010000, 1'b0); send(32'h00028000, 1'b0); send(32'h80010000, 1'b0);
    chk("pre_valid", {63'd0, out_valid}, 64'd0);
    send(32'h00008000, 1'b0);
    chk("latency", {63'd0, out_valid}, 64'd1);
    drain();
    chk("basic", {31'd0, last_l, last_d}, {31'd0, 33'h0_00028000});
    chk("basic_ready", 64'(ready_low), 64'd0);
    // all negative, with RELU clamp on the second instance
    window(32'h80010000, 32'h80008000, 32'h80030000, 32'h80020000);
    drain();
    chk("neg", {32'd0, last_d}, 64'h80008000);
    chk("neg_relu", {32'd0, last_dr}, 64'd0);
    window(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000);
    drain();
    chk("zero_sign", {32'd0, last_d}, 64'd0);
    window(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    drain();
    chk("tie", {32'd0, last_d}, 64'h00010000);
    // early close
    send(32'h00010000, 1'b0);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    send(32'h00020000, 1'b1);
    drain();
    chk("early", {31'd0, last_l, last_d}, {31'd0, 33'h1_00020000});
    chk("busy_idle", {63'd0, busy}, 64'd0);
    send(32'h80070000, 1'b1);
    drain();
    chk("single", {31'd0, last_l, last_d}, {31'd0, 33'h1_80070000});
    // back-pressure: first result must hold while the second window waits
    out_ready = 1'b0;
    window(32'h00010000, 32'h00040000, 32'h00030000, 32'h00020000);
    fork
      window(32'h00070000, 32'h80070000, 32'h00060000, 32'h00010000);
      begin
        repeat (5) begin
          @(posedge clk);
          #2;
          chk("bp_hold", {31'd0, out_valid, out_data}, {31'd0, 33'h1_00040000});
          chk("bp_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_second", {32'd0, last_d}, 64'h00070000);
    // random windows under random back-pressure
    n0 = n_out;
    rnd_on = 1'b1;
    fork
      begin
        for (int w = 0; w < 100; w++) begin
          int len;
          len = $urandom_range(1, WIN);
          for (int k = 0; k < len; k++) begin
            logic [31:0] d;
            d = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 40000))};
            send(d, k == len - 1 && (len < WIN || $urandom_range(0, 1) == 1));
          end
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk);
        #1;
        out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rnd_count", 64'(n_out - n0), 64'd100);
    // reset mid-window discards the partial window
    send(32'h00090000, 1'b0); send(32'h00080000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid", {62'd0, busy, out_valid}, 64'd0);
    n0 = n_out;
    window(32'h00050000, 32'h0, 32'h0, 32'h0);
    drain();
    chk("rst_after", {32'd0, last_d}, 64'h00050000);
    chk("rst_count", 64'(n_out - n0), 64'd1);
    // full throughput
    out_cyc.delete();
    ready_low = 0;
    for (int i = 0; i < 64; i++) send(32'(i * 32'h1000) ^ (i[0] ? 32'h80000000 : 32'h0), 1'b0);
    drain();
    chk("tp_count", 64'(out_cyc.size()), 64'd16);
    chk("tp_ready", 64'(ready_low), 64'd0);
    for (int i = 1; i < out_cyc.size(); i++) chk("tp_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'd4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
